ysyx_22040931_alu_issue: RTL and testbench
==========================================

# ysyx_22040931_alu_issue

Issue stage that drives the ALU's request/response handshake from the decode side. Accepts one decoded operation from decode. Holds its operands stable on the ALU inputs until the ALU, including the multi-cycle divider, returns a result. Captures the result in a write-back register for the next stage. Also handles pipeline flush around in-flight divides and flags a hung ALU with a watchdog.

## Interface
Parameters:
- DATA_W, 64, operand/result/pc width
- OP_W, 5, ALU op code width (matches ALU op bus)
- RD_W, 5, destination register index width
- TIMEOUT, 127, max cycles allowed in BUSY/DRAIN before err_timeout (≥2)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decode has an op
- in_ready  out  1  stage can accept an op this cycle
- in_op / in_num1 / in_num2 / in_imm / in_pc  in  OP_W / DATA_W ×4  decoded op and operands
- in_rd  in  RD_W  destination register
- in_wen  in  1  register write enable
- flush  in  1  synchronous kill of held/in-flight op
- id_valid  out  1  request valid to ALU
- ex_ready  out  1  issue can take ALU result
- alu_valid  in  1  ALU result valid
- alu_ready  in  1  ALU can accept (informational; ops never re-issued)
- op / num1 / num2 / imm / pc  out  OP_W / DATA_W ×4  registered ALU inputs
- out  in  DATA_W  ALU result
- wb_valid  out  1  result held for write-back
- wb_ready  in  1  write-back takes result
- wb_data  out  DATA_W  captured result
- wb_rd  out  RD_W  captured destination
- wb_wen  out  1  captured write enable
- err_timeout  out  1  sticky watchdog error

## Operation
- States: IDLE, BUSY, DRAIN, FULL. Reset → IDLE.
- IDLE:
  - in_ready=1.
  - in_valid && !flush: latch op, operands, rd, wen; go to BUSY.
- BUSY:
  - id_valid=1, ex_ready=1; ALU inputs held constant.
  - alu_valid && !flush: capture out, rd, wen into wb regs; go to FULL.
  - flush && alu_valid: discard; go to IDLE.
  - flush && !alu_valid: go to DRAIN, so an in-flight divide completes cleanly.
- DRAIN:
  - id_valid=1, ex_ready=1.
  - alu_valid: discard result; go to IDLE.
  - flush ignored (already draining).
- FULL:
  - wb_valid=1; in_ready=wb_ready.
  - wb_ready && in_valid: latch new op; go to BUSY.
  - wb_ready && !in_valid: go to IDLE.
  - flush: drop the result; go to IDLE. flush takes priority over wb_ready and in_valid.
- Watchdog:
  - Counter width is ceil(log2(TIMEOUT+1)). It clears on entry to BUSY/DRAIN and increments each cycle in BUSY/DRAIN, saturating.
  - When it reaches TIMEOUT, err_timeout is set. It stays set until reset; the state is unchanged.
- No arithmetic beyond the counter. All data is passed through at full width, with no sign extension.

## Timing
- Reset values:
  - in_ready=1.
  - id_valid, ex_ready, wb_valid, wb_wen, err_timeout = 0.
  - op, num1, num2, imm, pc, wb_data, wb_rd = 0.
- All outputs are registered or decoded from state only; no combinational path from any input to any output except in_ready←wb_ready in FULL.
- Single-cycle op (alu_valid=1 in the same cycle as id_valid):
  - accept at edge 0 → BUSY in cycle 1 → wb_valid in cycle 2.
  - Acceptance-to-wb latency 2; throughput one op per 2 cycles.
- Divide taking N cycles of alu_valid=0 in BUSY: wb_valid at cycle 2+N.
- id_valid deasserts the cycle after the result is captured.
- Reset asserted mid-divide returns to IDLE immediately; the ALU divider shares the same reset.

## Test plan
- Reset:
  - Stimulus: hold reset=0 for 3 cycles with random inputs.
  - Required: in_ready=1 and all other outputs 0 throughout.
- ADD:
  - Stimulus: in_valid with num1=5, num2=7; ALU returns out=12 with alu_valid=1; wb_ready=1.
  - Required: id_valid high in cycle 1 only; wb_valid=1, wb_data=12 in cycle 2; in_ready=1 in cycle 3.
- Divide with back-pressure:
  - Stimulus: alu_valid held 0 for 10 cycles then out=3; wb_ready=0 for 4 cycles.
  - Required: num1/num2/op stable for all 11 BUSY cycles; wb_valid at cycle 12, held with wb_data=3 until wb_ready; no new op accepted meanwhile.
- Flush mid-divide:
  - Stimulus: flush in the 3rd BUSY cycle of a 10-cycle divide.
  - Required: DRAIN, id_valid stays 1; on alu_valid → IDLE; wb_valid never asserts; in_ready returns to 1.
- Back-to-back:
  - Stimulus: FULL with wb_ready=1 and in_valid=1 simultaneously.
  - Required: the new op is latched in the same edge and id_valid=1 the next cycle; the old result is consumed exactly once.
- Watchdog:
  - Stimulus: TIMEOUT=8, alu_valid stuck 0.
  - Required: err_timeout rises after the 8th BUSY cycle and stays 1 after a later alu_valid; cleared only by reset.

Source files
------------

// File: rtl/ysyx_22040931_alu_issue.sv
// ysyx_22040931_alu_issue
//   Issue stage between decode and the ALU. One op is latched from decode and
//   held on the ALU inputs until the ALU (including the multi-cycle divider)
//   returns a result. The result is parked in a write-back register until the
//   next stage takes it. A flush during an outstanding divide parks the stage
//   in DRAIN until the divider finishes, so the ALU is never left mid-op.
//   A watchdog flags an ALU that never answers.
//
// Ports
//   clock, reset            rising-edge clock, async active-low reset
//   in_*                    decode handshake and decoded op/operands
//   flush                   synchronous kill of the held / in-flight op
//   id_valid, ex_ready      request / result handshake toward the ALU
//   alu_valid, alu_ready    ALU result valid / ALU can accept
//   op,num1,num2,imm,pc     registered ALU inputs
//   out                     ALU result
//   wb_*                    captured result for write-back
//   err_timeout             sticky watchdog error
module ysyx_22040931_alu_issue #(
    parameter int DATA_W  = 64,
    parameter int OP_W    = 5,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 127
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_num1,
    input  logic [DATA_W-1:0] in_num2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wen,
    input  logic              flush,
    output logic              id_valid,
    output logic              ex_ready,
    input  logic              alu_valid,
    input  logic              alu_ready,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] num1,
    output logic [DATA_W-1:0] num2,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] out,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_wen,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, FULL} state_t;

    state_t            state, state_nxt;
    logic [RD_W-1:0]   hold_rd;
    logic              hold_wen;
    logic [CNT_W-1:0]  wd_cnt;
    logic              accept, capture, waiting, entering;

    // Ops are never re-issued, so the ALU's ready is not needed for control.
    logic unused_alu_ready;
    assign unused_alu_ready = alu_ready;

    // A new op enters from IDLE, or from FULL in the same edge the old result
    // is consumed. Flush kills an op arriving in that cycle.
    assign accept  = in_valid && !flush &&
                     ((state == IDLE) || (state == FULL && wb_ready));
    assign capture = (state == BUSY) && alu_valid && !flush;
    assign waiting = (state == BUSY) || (state == DRAIN);
    assign entering = ((state_nxt == BUSY) || (state_nxt == DRAIN)) &&
                      (state_nxt != state);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_valid && !flush) state_nxt = BUSY;
            BUSY: begin
                if (flush)          state_nxt = alu_valid ? IDLE : DRAIN;
                else if (alu_valid) state_nxt = FULL;
            end
            DRAIN: if (alu_valid) state_nxt = IDLE;
            FULL: begin
                if (flush)         state_nxt = IDLE;
                else if (wb_ready) state_nxt = in_valid ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; in_ready in FULL is the only input path.
    always_comb begin
        in_ready = 1'b0;
        id_valid = 1'b0;
        ex_ready = 1'b0;
        wb_valid = 1'b0;
        case (state)
            IDLE:        in_ready = 1'b1;
            BUSY, DRAIN: begin
                id_valid = 1'b1;
                ex_ready = 1'b1;
            end
            FULL: begin
                wb_valid = 1'b1;
                in_ready = wb_ready;
            end
            default: ;
        endcase
    end

    // Operand hold registers: only written on accept, so the ALU sees them
    // stable for the whole BUSY/DRAIN window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op       <= '0;
            num1     <= '0;
            num2     <= '0;
            imm      <= '0;
            pc       <= '0;
            hold_rd  <= '0;
            hold_wen <= 1'b0;
        end else if (accept) begin
            op       <= in_op;
            num1     <= in_num1;
            num2     <= in_num2;
            imm      <= in_imm;
            pc       <= in_pc;
            hold_rd  <= in_rd;
            hold_wen <= in_wen;
        end
    end

    // Write-back register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_data <= '0;
            wb_rd   <= '0;
            wb_wen  <= 1'b0;
        end else if (capture) begin
            wb_data <= out;
            wb_rd   <= hold_rd;
            wb_wen  <= hold_wen;
        end
    end

    // Watchdog: the error rises on the edge that brings the count to TIMEOUT,
    // i.e. at the end of the TIMEOUT-th waiting cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else if (entering) begin
            wd_cnt <= '0;
        end else if (waiting && wd_cnt != CNT_W'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == CNT_W'(TIMEOUT - 1)) err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_alu_issue.sv
module tb_ysyx_22040931_alu_issue;
    localparam int DATA_W = 64, OP_W = 5, RD_W = 5, TIMEOUT = 8;

    logic              clock, reset;
    logic              in_valid, in_ready, in_wen, flush;
    logic [OP_W-1:0]   in_op, op;
    logic [DATA_W-1:0] in_num1, in_num2, in_imm, in_pc;
    logic [RD_W-1:0]   in_rd, wb_rd;
    logic              id_valid, ex_ready, alu_valid, alu_ready;
    logic [DATA_W-1:0] num1, num2, imm, pc, alu_out, wb_data;
    logic              wb_valid, wb_ready, wb_wen, err_timeout;

    int checks = 0;
    int fails  = 0;

    ysyx_22040931_alu_issue #(
        .DATA_W(DATA_W), .OP_W(OP_W), .RD_W(RD_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_num1(in_num1), .in_num2(in_num2),
        .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd), .in_wen(in_wen),
        .flush(flush), .id_valid(id_valid), .ex_ready(ex_ready),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .op(op), .num1(num1), .num2(num2), .imm(imm), .pc(pc),
        .out(alu_out), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .err_timeout(err_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; flush = 0; alu_valid = 0; alu_ready = 1; wb_ready = 0;
        in_op = '0; in_num1 = '0; in_num2 = '0; in_imm = '0; in_pc = '0;
        in_rd = '0; in_wen = 0; alu_out = '0;
    endtask

    task automatic test_reset();
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'($urandom); flush = 1'($urandom);
            alu_valid = 1'($urandom); alu_ready = 1'($urandom);
            wb_ready = 1'($urandom); in_wen = 1'($urandom);
            in_op = 5'($urandom); in_rd = 5'($urandom);
            in_num1 = {$urandom, $urandom}; in_num2 = {$urandom, $urandom};
            in_imm = {$urandom, $urandom}; in_pc = {$urandom, $urandom};
            alu_out = {$urandom, $urandom};
            tick();
            checks++;
            if (in_ready !== 1'b1) begin
                fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
            end
            checks++;
            if ({id_valid, ex_ready, wb_valid, wb_wen, err_timeout, op, num1,
                 num2, imm, pc, wb_data, wb_rd} !== '0) begin
                fails++;
                $display("FAIL reset_outputs: id_valid=%b ex_ready=%b wb_valid=%b wb_wen=%b err=%b num1=%h wb_data=%h expected all 0",
                         id_valid, ex_ready, wb_valid, wb_wen, err_timeout, num1, wb_data);
            end
        end
        idle_inputs();
        reset = 1;
    endtask

    task automatic test_add();
        in_op = 5'd1; in_num1 = 64'd5; in_num2 = 64'd7; in_imm = 64'd0;
        in_pc = 64'h8000_0000; in_rd = 5'd10; in_wen = 1; in_valid = 1;
        tick();                                   // cycle 1
        in_valid = 0; alu_valid = 1; alu_out = 64'd12; wb_ready = 1;
        checks++;
        if ({id_valid, ex_ready, wb_valid, in_ready} !== 4'b1100) begin
            fails++; $display("FAIL add_c1_ctrl: got %b expected 1100", {id_valid, ex_ready, wb_valid, in_ready});
        end
        checks++;
        if (num1 !== 64'd5 || num2 !== 64'd7 || op !== 5'd1 || pc !== 64'h8000_0000) begin
            fails++; $display("FAIL add_operands: got num1=%0d num2=%0d op=%0d pc=%h expected 5 7 1 80000000", num1, num2, op, pc);
        end
        tick();                                   // cycle 2
        alu_valid = 0;
        checks++;
        if ({id_valid, wb_valid, in_ready} !== 3'b011) begin
            fails++; $display("FAIL add_c2_ctrl: got %b expected 011", {id_valid, wb_valid, in_ready});
        end
        checks++;
        if (wb_data !== 64'd12 || wb_rd !== 5'd10 || wb_wen !== 1'b1) begin
            fails++; $display("FAIL add_wb: got data=%0d rd=%0d wen=%b expected 12 10 1", wb_data, wb_rd, wb_wen);
        end
        tick();                                   // cycle 3
        wb_ready = 0;
        checks++;
        if ({id_valid, wb_valid, in_ready} !== 3'b001) begin
            fails++; $display("FAIL add_c3_ctrl: got %b expected 001", {id_valid, wb_valid, in_ready});
        end
    endtask

    task automatic test_divide_backpressure();
        in_op = 5'd4; in_num1 = 64'd100; in_num2 = 64'd33; in_imm = 64'h10;
        in_pc = 64'h8000_0004; in_rd = 5'd3; in_wen = 1; in_valid = 1; wb_ready = 0;
        tick();                                   // cycle 1
        for (int c = 1; c <= 11; c++) begin
            // decode keeps offering a different op; it must not be taken
            in_valid = 1; in_op = 5'd9; in_num1 = 64'hdead; in_num2 = 64'hbeef;
            alu_valid = (c == 11);
            alu_out = (c == 11) ? 64'd3 : 64'hbad;
            checks++;
            if ({id_valid, wb_valid, in_ready} !== 3'b100) begin
                fails++; $display("FAIL div_busy_ctrl c%0d: got %b expected 100", c, {id_valid, wb_valid, in_ready});
            end
            checks++;
            if (num1 !== 64'd100 || num2 !== 64'd33 || op !== 5'd4) begin
                fails++; $display("FAIL div_hold c%0d: got num1=%0d num2=%0d op=%0d expected 100 33 4", c, num1, num2, op);
            end
            tick();
        end
        alu_valid = 0;
        for (int c = 12; c <= 15; c++) begin
            checks++;
            if ({id_valid, wb_valid, in_ready} !== 3'b010 || wb_data !== 64'd3 || wb_rd !== 5'd3) begin
                fails++; $display("FAIL div_full c%0d: got ctrl=%b data=%0d rd=%0d expected 010 3 3",
                                  c, {id_valid, wb_valid, in_ready}, wb_data, wb_rd);
            end
            checks++;
            if (num1 !== 64'd100) begin
                fails++; $display("FAIL div_no_accept c%0d: got num1=%h expected 64", c, num1);
            end
            tick();
        end
        in_valid = 0; wb_ready = 1;
        #1;
        checks++;
        if ({wb_valid, in_ready} !== 2'b11) begin
            fails++; $display("FAIL div_release: got %b expected 11", {wb_valid, in_ready});
        end
        tick();                                   // cycle 17
        wb_ready = 0;
        checks++;
        if ({id_valid, wb_valid, in_ready} !== 3'b001) begin
            fails++; $display("FAIL div_idle: got %b expected 001", {id_valid, wb_valid, in_ready});
        end
    endtask

    task automatic test_flush_divide();
        in_op = 5'd5; in_num1 = 64'd50; in_num2 = 64'd7; in_rd = 5'd4; in_valid = 1;
        tick();                                   // cycle 1
        in_valid = 0;
        for (int c = 1; c <= 11; c++) begin
            flush = (c == 3) || (c == 5);         // second flush lands in DRAIN
            alu_valid = (c == 11);
            alu_out = 64'd7;
            checks++;
            if ({id_valid, ex_ready, wb_valid, in_ready} !== 4'b1100) begin
                fails++; $display("FAIL flush_wait c%0d: got %b expected 1100", c, {id_valid, ex_ready, wb_valid, in_ready});
            end
            tick();
        end
        flush = 0; alu_valid = 0;
        for (int c = 12; c <= 13; c++) begin
            checks++;
            if ({id_valid, wb_valid, in_ready} !== 3'b001) begin
                fails++; $display("FAIL flush_idle c%0d: got %b expected 001", c, {id_valid, wb_valid, in_ready});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        in_op = 5'd1; in_num1 = 64'd1; in_num2 = 64'd2; in_rd = 5'd1; in_wen = 1; in_valid = 1;
        tick();                                   // cycle 1
        in_valid = 0; alu_valid = 1; alu_out = 64'd3;
        tick();                                   // cycle 2: FULL with A
        alu_valid = 0; wb_ready = 1;
        in_valid = 1; in_num1 = 64'd4; in_num2 = 64'd5; in_rd = 5'd2; in_wen = 0;
        #1;
        checks++;
        if ({wb_valid, in_ready} !== 2'b11 || wb_data !== 64'd3 || wb_rd !== 5'd1) begin
            fails++; $display("FAIL b2b_first: got ctrl=%b data=%0d rd=%0d expected 11 3 1", {wb_valid, in_ready}, wb_data, wb_rd);
        end
        tick();                                   // cycle 3: BUSY with B
        in_valid = 0; wb_ready = 0; alu_valid = 1; alu_out = 64'd9;
        checks++;
        if ({id_valid, wb_valid} !== 2'b10 || num1 !== 64'd4 || num2 !== 64'd5) begin
            fails++; $display("FAIL b2b_second_issue: got ctrl=%b num1=%0d num2=%0d expected 10 4 5", {id_valid, wb_valid}, num1, num2);
        end
        tick();                                   // cycle 4
        alu_valid = 0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 64'd9 || wb_rd !== 5'd2 || wb_wen !== 1'b0) begin
            fails++; $display("FAIL b2b_second_wb: got v=%b data=%0d rd=%0d wen=%b expected 1 9 2 0", wb_valid, wb_data, wb_rd, wb_wen);
        end
        // flush wins over wb_ready and in_valid in FULL
        flush = 1; wb_ready = 1; in_valid = 1; in_num1 = 64'd77;
        tick();
        flush = 0; wb_ready = 0; in_valid = 0;
        checks++;
        if ({id_valid, wb_valid, in_ready} !== 3'b001 || num1 !== 64'd4) begin
            fails++; $display("FAIL full_flush: got ctrl=%b num1=%0d expected 001 4", {id_valid, wb_valid, in_ready}, num1);
        end
    endtask

    task automatic test_watchdog();
        reset = 0; #1; reset = 1;
        checks++;
        if (err_timeout !== 1'b0) begin
            fails++; $display("FAIL wd_cleared_by_reset: got %b expected 0", err_timeout);
        end
        in_op = 5'd6; in_num1 = 64'd11; in_valid = 1;
        tick();                                   // cycle 1
        in_valid = 0;
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (id_valid !== 1'b1 || err_timeout !== (c >= 9)) begin
                fails++; $display("FAIL wd_busy c%0d: got id_valid=%b err=%b expected 1 %b", c, id_valid, err_timeout, c >= 9);
            end
            tick();
        end
        alu_valid = 1; alu_out = 64'd1;
        tick();
        alu_valid = 0;
        checks++;
        if (wb_valid !== 1'b1 || err_timeout !== 1'b1) begin
            fails++; $display("FAIL wd_sticky_full: got wb_valid=%b err=%b expected 1 1", wb_valid, err_timeout);
        end
        wb_ready = 1;
        tick();
        wb_ready = 0;
        checks++;
        if (in_ready !== 1'b1 || err_timeout !== 1'b1) begin
            fails++; $display("FAIL wd_sticky_idle: got in_ready=%b err=%b expected 1 1", in_ready, err_timeout);
        end
        // reset in the middle of an outstanding op
        in_num1 = 64'd22; in_valid = 1;
        tick();
        in_valid = 0;
        checks++;
        if (id_valid !== 1'b1 || num1 !== 64'd22) begin
            fails++; $display("FAIL mid_reset_pre: got id_valid=%b num1=%0d expected 1 22", id_valid, num1);
        end
        reset = 0; #1;
        checks++;
        if ({id_valid, in_ready, err_timeout} !== 3'b010 || num1 !== '0) begin
            fails++; $display("FAIL mid_reset: got ctrl=%b num1=%0d expected 010 0", {id_valid, in_ready, err_timeout}, num1);
        end
        reset = 1;
        tick();
        checks++;
        if ({id_valid, in_ready, wb_valid} !== 3'b010) begin
            fails++; $display("FAIL post_reset_idle: got %b expected 010", {id_valid, in_ready, wb_valid});
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_add();
        test_divide_backpressure();
        test_flush_divide();
        test_back_to_back();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
